// File: rtl/wt_cache_pkg.sv
// Shared types, geometry and address helpers for the write-through cache controller.
package wt_cache_pkg;

  localparam int ADDR_WIDTH = 28;
  localparam int DATA_WIDTH = 32;
  localparam int INDEX_BITS = 4;
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;
  localparam int NUM_LINES  = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS-1:0]   tag;
    logic [DATA_WIDTH-1:0] data;
  } line_t;

  function automatic logic [INDEX_BITS-1:0] idx_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[INDEX_BITS-1:0];
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:INDEX_BITS];
  endfunction

endpackage

// File: rtl/wt_cache_array.sv
// Line storage: combinational read by index, one write port, valid bits with async clear and flush-all.
module wt_cache_array
  import wt_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_all,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  valid_d;
  logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

  // Next valid vector: flush wipes every line, a write marks its line valid.
  always_comb begin
    valid_d = valid_q;
    if (flush_all) begin
      valid_d = {NUM_LINES{1'b0}};
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only state that must come up clean after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {NUM_LINES{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/wt_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller with registered CPU and memory sides.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module wt_cache_ctrl
  import wt_cache_pkg::*;
#(
  parameter int MEM_LAT = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  flush,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hit_q, hit_d;
  logic [2:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  line_t                 line_s;
  logic                  hit_s;
  logic                  flush_all_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  wt_cache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .flush_all (flush_all_s),
    .rd_idx    (idx_of(addr_q)),
    .rd_valid  (line_s.valid),
    .rd_tag    (line_s.tag),
    .rd_data   (line_s.data),
    .wr_en     (wr_en_s),
    .wr_idx    (idx_of(addr_q)),
    .wr_tag    (tag_of(addr_q)),
    .wr_data   (wr_data_s)
  );

  assign hit_s = line_s.valid && (line_s.tag == tag_of(addr_q));

  // FSM next-state and next-output logic; the fill wait counter runs inside FILL.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_oe_d    = mem_oe_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    flush_all_s = 1'b0;
    wr_en_s     = 1'b0;
    wr_data_s   = {DATA_WIDTH{1'b0}};
    case (state_q)
      IDLE: begin
        if (flush) begin
          flush_all_s = 1'b1;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        hit_d = hit_s;
        if (we_q) begin
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_oe_d    = 1'b0;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = WRITE;
        end else if (hit_s) begin
          cpu_rdata_d = line_s.data;
          cpu_ready_d = 1'b1;
          state_d     = RESP;
        end else begin
          mem_cs_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_oe_d   = 1'b1;
          mem_addr_d = addr_q;
          wait_d     = 3'd0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (wait_q == LAT_LAST) begin
          wr_en_s     = 1'b1;
          wr_data_s   = mem_rdata;
          cpu_rdata_d = mem_rdata;
          cpu_ready_d = 1'b1;
          mem_cs_d    = 1'b0;
          mem_oe_d    = 1'b0;
          wait_d      = 3'd0;
          state_d     = RESP;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      WRITE: begin
        // Write-through: a resident line follows memory, a miss leaves the cache alone.
        if (hit_q) begin
          wr_en_s   = 1'b1;
          wr_data_s = wdata_q;
        end else begin
          wr_en_s = 1'b0;
        end
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ready_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        mem_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // All controller state and outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      we_q        <= 1'b0;
      wdata_q     <= {DATA_WIDTH{1'b0}};
      hit_q       <= 1'b0;
      wait_q      <= 3'd0;
      cpu_rdata_q <= {DATA_WIDTH{1'b0}};
      cpu_ready_q <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        load_lookup_s;

  // Loads are classified once, in LOOKUP; both counters saturate.
  always_comb begin
    load_lookup_s = (state_q == LOOKUP) && !we_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    if (load_lookup_s && hit_s) begin
      if (hit_cnt_q != 32'hFFFF_FFFF) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        hit_cnt_d = hit_cnt_q;
      end
    end else if (load_lookup_s) begin
      if (miss_cnt_q != 32'hFFFF_FFFF) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q;
      end
    end else begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers; flush deliberately does not touch them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_wt_cache_ctrl.sv
// Self-checking bench for wt_cache_ctrl: line-level cache model, bus monitor and directed access vectors.
module tb_wt_cache_ctrl;
  import wt_cache_pkg::*;

  localparam int MEM_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cpu_req = 1'b0;
  logic                  cpu_we = 1'b0;
  logic [ADDR_WIDTH-1:0] cpu_addr = '0;
  logic [DATA_WIDTH-1:0] cpu_wdata = '0;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;
  logic                  flush = 1'b0;
  logic                  mem_cs, mem_we, mem_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]           hit_cnt, miss_cnt;
`endif

  wt_cache_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .flush     (flush),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  // Environment memory (bus side) and the model's own view of memory.
  logic [31:0] ram       [0:4095];
  logic [31:0] model_mem [0:4095];
  assign mem_rdata = (mem_cs && mem_oe) ? ram[mem_addr[11:0]] : 32'h0;

  // Model: one entry per line, plus load hit/miss tallies.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16];
  int          m_hits   = 0;
  int          m_misses = 0;

  typedef struct {
    bit          we;
    logic [27:0] addr;
    logic [31:0] wdata;
  } op_t;
  op_t obs_q[$];

  bit          in_txn = 1'b0;
  bit          exp_load = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        prev_cs = 1'b0;

  // Compare process: bus sanity, memory op capture and response data, sampled 2 after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (mem_cs && !prev_cs) begin
          obs_q.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) ram[mem_addr[11:0]] = mem_wdata;
        end
        if (mem_cs) check("bus_dir", 64'(mem_we ^ mem_oe), 64'd1);
        else        check("bus_quiet", 64'(mem_we | mem_oe), 64'd0);
        if (cpu_ready) begin
          check("ready_expected", 64'(in_txn), 64'd1);
          if (in_txn && exp_load) check("rdata", 64'(cpu_rdata), 64'(exp_rdata));
        end
      end
      prev_cs = mem_cs;
    end
  end

  task automatic model_invalidate();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // One CPU access: predicts from the model, drives the handshake, checks latency and bus ops.
  task automatic access(input bit we, input logic [27:0] addr, input logic [31:0] wdata,
                        input bit with_flush, input bit chk_lit, input int lit_lat,
                        input logic [31:0] lit_rdata);
    logic [3:0]  idx;
    logic [23:0] tg;
    bit          hit;
    int          exp_lat;
    bit          has_op;
    op_t         e_op;
    int          lat;
    idx = addr[3:0];
    tg  = addr[27:4];
    if (with_flush) model_invalidate();
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (we) begin
      exp_lat = 3;
      has_op  = 1'b1;
      e_op    = '{1'b1, addr, wdata};
      model_mem[addr[11:0]] = wdata;
      if (hit) m_data[idx] = wdata;
    end else if (hit) begin
      exp_lat   = 2;
      has_op    = 1'b0;
      e_op      = '{1'b0, addr, 32'h0};
      exp_rdata = m_data[idx];
      m_hits++;
    end else begin
      exp_lat   = 2 + MEM_LAT;
      has_op    = 1'b1;
      e_op      = '{1'b0, addr, 32'h0};
      exp_rdata = model_mem[addr[11:0]];
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = exp_rdata;
      m_misses++;
    end
    if (with_flush) exp_lat = exp_lat + 1;
    obs_q.delete();
    exp_load = !we;
    @(negedge clk);
    in_txn    = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    flush     = with_flush;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      flush = 1'b0;
      if (cpu_ready) begin
        lat = e;
        break;
      end
    end
    cpu_req = 1'b0;
    in_txn  = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("mem_op_count", 64'(obs_q.size()), 64'(has_op));
    if (has_op && obs_q.size() > 0) begin
      check("mem_op_we", 64'(obs_q[0].we), 64'(e_op.we));
      check("mem_op_addr", 64'(obs_q[0].addr), 64'(e_op.addr));
      if (we) check("mem_op_wdata", 64'(obs_q[0].wdata), 64'(e_op.wdata));
    end
    if (chk_lit) begin
      check("lit_latency", 64'(lat), 64'(lit_lat));
      if (!we) check("lit_rdata", 64'(cpu_rdata), 64'(lit_rdata));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]       = {20'hA5A00, 12'(i)};
      model_mem[i] = {20'hA5A00, 12'(i)};
    end
    ram['h11E] = 32'h7800_0000;  model_mem['h11E] = 32'h7800_0000;
    ram['h120] = 32'h7800_0001;  model_mem['h120] = 32'h7800_0001;
    model_invalidate();

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_mem_ctl", 64'({mem_cs, mem_we, mem_oe}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
`ifdef CACHE_STATS_EN
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
    rst = 1'b0;

    // Cold load, then the same load hits
    access(1'b0, 28'h11E, 32'h0, 1'b0, 1'b1, 3, 32'h7800_0000);
    access(1'b0, 28'h11E, 32'h0, 1'b0, 1'b1, 2, 32'h7800_0000);
    // Store hit is written through and updates the line
    access(1'b0, 28'h120, 32'h0, 1'b0, 1'b1, 3, 32'h7800_0001);
    access(1'b1, 28'h120, 32'h5, 1'b0, 1'b1, 3, 32'h0);
    access(1'b0, 28'h120, 32'h0, 1'b0, 1'b1, 2, 32'h5);
    // Store miss does not allocate
    access(1'b1, 28'h11C, 32'hA, 1'b0, 1'b1, 3, 32'h0);
    access(1'b0, 28'h11C, 32'h0, 1'b0, 1'b1, 3, 32'hA);
    // Conflict on index 4 evicts in place
    access(1'b0, 28'h0000104, 32'h0, 1'b0, 1'b1, 3, 32'hA5A0_0104);
    access(1'b0, 28'h0000114, 32'h0, 1'b0, 1'b1, 3, 32'hA5A0_0114);
    access(1'b0, 28'h0000104, 32'h0, 1'b0, 1'b1, 3, 32'hA5A0_0104);
    // Top address, last index
    access(1'b0, 28'hFFFFFFF, 32'h0, 1'b0, 1'b1, 3, 32'hA5A0_0FFF);
    access(1'b0, 28'hFFFFFFF, 32'h0, 1'b0, 1'b1, 2, 32'hA5A0_0FFF);
    access(1'b0, 28'h000000F, 32'h0, 1'b0, 1'b1, 3, 32'hA5A0_000F);
    // Flush together with a request: flush first, then the request misses
    access(1'b0, 28'h100, 32'h0, 1'b0, 1'b1, 3, 32'hA5A0_0100);
    access(1'b0, 28'h100, 32'h0, 1'b0, 1'b1, 2, 32'hA5A0_0100);
    access(1'b0, 28'h100, 32'h0, 1'b1, 1'b1, 4, 32'hA5A0_0100);
`ifdef CACHE_STATS_EN
    check("stats_hits_model", 64'(hit_cnt), 64'(m_hits));
    check("stats_miss_model", 64'(miss_cnt), 64'(m_misses));
`endif

    // Reset during FILL aborts with no response
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 28'h130;
    repeat (2) @(negedge clk);
    check("fill_cs_before_rst", 64'(mem_cs), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_cs", 64'({mem_cs, mem_oe}), 64'd0);
    check("rst_mid_ready", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_invalidate();
    m_hits   = 0;
    m_misses = 0;
    obs_q.delete();

    // After reset every line is invalid; 2 misses then 3 hits
    access(1'b0, 28'h11E, 32'h0, 1'b0, 1'b1, 3, 32'h7800_0000);
    access(1'b0, 28'h100, 32'h0, 1'b0, 1'b1, 3, 32'hA5A0_0100);
    access(1'b0, 28'h11E, 32'h0, 1'b0, 1'b1, 2, 32'h7800_0000);
    access(1'b0, 28'h100, 32'h0, 1'b0, 1'b1, 2, 32'hA5A0_0100);
    access(1'b0, 28'h11E, 32'h0, 1'b0, 1'b1, 2, 32'h7800_0000);

    // Standalone flush pulse
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_invalidate();
`ifdef CACHE_STATS_EN
    check("stats_hit_3", 64'(hit_cnt), 64'd3);
    check("stats_miss_2", 64'(miss_cnt), 64'd2);
    check("stats_hits_model2", 64'(hit_cnt), 64'(m_hits));
`endif
    access(1'b0, 28'h11E, 32'h0, 1'b0, 1'b1, 3, 32'h7800_0000);
    access(1'b1, 28'h11E, 32'h1234_5678, 1'b0, 1'b1, 3, 32'h0);
    access(1'b0, 28'h11E, 32'h0, 1'b0, 1'b1, 2, 32'h1234_5678);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
